// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, states,
// ALU operation codes, mux select values and the control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BROFF  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_t;

  // States that wait on mem_ready and are therefore guarded by the timer
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent in a memory state without mem_ready; flags expiry.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic expired
);

  localparam int unsigned CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  logic [CW-1:0] r_count;

  // Wait counter: cleared on state entry/abort, advances while memory stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !ready && !expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == CW'(MEM_WAIT_MAX));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait timeout and retire counter.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op,
  output logic        mem_err,
  output logic [31:0] instr_count
);

  state_t      r_state;
  state_t      w_next;
  ctrl_t       w_ctrl;
  logic [5:0]  r_opcode;
  logic [31:0] r_instr_count;
  logic        w_expired;
  logic        w_wait_en;
  logic        w_abort;
  logic        w_timer_clear;

  assign w_wait_en     = is_mem_state(r_state);
  assign w_abort       = w_wait_en && w_expired && !mem_ready;
  assign w_timer_clear = (w_next != r_state) || w_abort;

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_timer_clear),
    .enable  (w_wait_en),
    .ready   (mem_ready),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode captured in DECODE so later states do not depend on the live bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_opcode <= '0;
    end else if (r_state == S_DECODE) begin
      r_opcode <= opcode;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_en    = 1'b1;
          w_next          = S_DECODE;
        end else if (w_expired) begin
          w_ctrl.mem_err = 1'b1;
          w_next         = S_FETCH;
        end
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_BROFF;
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default: begin
            w_ctrl.illegal_op = 1'b1;
            w_next            = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_next           = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_expired) begin
          w_ctrl.mem_err = 1'b1;
          w_next         = S_FETCH;
        end
      end
      S_MEMWB: begin
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEMWR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
        if (mem_ready) begin
          w_ctrl.instr_done = 1'b1;
          w_next            = S_FETCH;
        end else if (w_expired) begin
          w_ctrl.mem_err = 1'b1;
          w_next         = S_FETCH;
        end
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
        w_next           = S_ALUWB;
      end
      S_ALUWB: begin
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
        w_next            = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a  = 1'b1;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.pc_src     = PCSRC_ALUOUT;
        w_ctrl.pc_en      = zero;
        w_ctrl.instr_done = 1'b1;
        w_next            = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_src     = PCSRC_JUMP;
        w_ctrl.pc_en      = 1'b1;
        w_ctrl.instr_done = 1'b1;
        w_next            = S_FETCH;
      end
      S_ADDIEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_next           = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
        w_next            = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_count <= '0;
    end else if (w_ctrl.instr_done) begin
      r_instr_count <= r_instr_count + 32'(1);
    end
  end

  // Strobes and pulses are forced low while reset is held
  assign pc_en       = w_ctrl.pc_en      && reset;
  assign ir_write    = w_ctrl.ir_write   && reset;
  assign reg_write   = w_ctrl.reg_write  && reset;
  assign mem_read    = w_ctrl.mem_read   && reset;
  assign mem_write   = w_ctrl.mem_write  && reset;
  assign instr_done  = w_ctrl.instr_done && reset;
  assign illegal_op  = w_ctrl.illegal_op && reset;
  assign mem_err     = w_ctrl.mem_err    && reset;
  assign iord        = w_ctrl.iord;
  assign reg_dst     = w_ctrl.reg_dst;
  assign mem_to_reg  = w_ctrl.mem_to_reg;
  assign alu_src_a   = w_ctrl.alu_src_a;
  assign alu_src_b   = w_ctrl.alu_src_b;
  assign alu_op      = w_ctrl.alu_op;
  assign pc_src      = w_ctrl.pc_src;
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed and random instruction streams
// compared cycle by cycle against an instruction-level expectation builder.
module tb_mips_multicycle_ctrl;

  localparam int unsigned MAXW = 3;

  localparam logic [17:0] B_PCEN  = 18'h20000;
  localparam logic [17:0] B_IRW   = 18'h10000;
  localparam logic [17:0] B_RW    = 18'h08000;
  localparam logic [17:0] B_MRD   = 18'h04000;
  localparam logic [17:0] B_MWR   = 18'h02000;
  localparam logic [17:0] B_IORD  = 18'h01000;
  localparam logic [17:0] B_RDST  = 18'h00800;
  localparam logic [17:0] B_M2R   = 18'h00400;
  localparam logic [17:0] B_SRCA  = 18'h00200;
  localparam logic [17:0] B_SB01  = 18'h00080;
  localparam logic [17:0] B_SB10  = 18'h00100;
  localparam logic [17:0] B_SB11  = 18'h00180;
  localparam logic [17:0] B_AO01  = 18'h00020;
  localparam logic [17:0] B_AO10  = 18'h00040;
  localparam logic [17:0] B_PS01  = 18'h00008;
  localparam logic [17:0] B_PS10  = 18'h00010;
  localparam logic [17:0] B_DONE  = 18'h00004;
  localparam logic [17:0] B_ILL   = 18'h00002;
  localparam logic [17:0] B_ERR   = 18'h00001;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, ir_write, reg_write, mem_read, mem_write;
  logic        iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic        instr_done, illegal_op, mem_err;
  logic [31:0] instr_count;
  logic [17:0] dut_vec;
  logic [7:0]  dut_strobes;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .iord        (iord),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_src      (pc_src),
    .state       (state),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .mem_err     (mem_err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pc_en, ir_write, reg_write, mem_read, mem_write, iord, reg_dst,
                    mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                    instr_done, illegal_op, mem_err};
  assign dut_strobes = {pc_en, ir_write, reg_write, mem_read, mem_write,
                        instr_done, illegal_op, mem_err};

  typedef struct {
    int          st;
    logic        rdy;
    logic [17:0] vec;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt;
  logic [5:0]  cur_op;
  logic        cur_zero;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
  endfunction

  function automatic void push(input int st, input logic rdy, input logic [17:0] v);
    exp_t e;
    e.st  = st;
    e.rdy = rdy;
    e.vec = v;
    q.push_back(e);
  endfunction

  // Memory phase: w idle cycles then ready; stalls reaching MAXW abort instead
  function automatic bit push_mem(input int st, input logic [17:0] base,
                                  input logic [17:0] on_ready, input int w);
    for (int k = 0; k <= int'(MAXW); k++) begin
      if (k == w) begin
        push(st, 1'b1, base | on_ready);
        return 1'b1;
      end
      if (k == int'(MAXW)) begin
        push(st, 1'b0, base | B_ERR);
        return 1'b0;
      end
      push(st, 1'b0, base);
    end
    return 1'b0;
  endfunction

  // Expected cycle sequence of one instruction from fetch to retirement
  function automatic void build(input logic [5:0] op, input logic z, input int wf, input int wm);
    if (!push_mem(0, B_MRD | B_SB01, B_IRW | B_PCEN, wf)) return;
    if (!is_legal(op)) begin
      push(1, 1'($urandom), B_SB11 | B_ILL);
      return;
    end
    push(1, 1'($urandom), B_SB11);
    case (op)
      6'b000000: begin
        push(6, 1'($urandom), B_SRCA | B_AO10);
        push(7, 1'($urandom), B_RDST | B_RW | B_DONE);
      end
      6'b100011: begin
        push(2, 1'($urandom), B_SRCA | B_SB10);
        if (push_mem(3, B_IORD | B_MRD, 18'h0, wm))
          push(4, 1'($urandom), B_M2R | B_RW | B_DONE);
      end
      6'b101011: begin
        push(2, 1'($urandom), B_SRCA | B_SB10);
        void'(push_mem(5, B_IORD | B_MWR, B_DONE, wm));
      end
      6'b000100: push(8, 1'($urandom), B_SRCA | B_AO01 | B_PS01 | B_DONE | (z ? B_PCEN : 18'h0));
      6'b000010: push(9, 1'($urandom), B_PS10 | B_PCEN | B_DONE);
      default: begin
        push(10, 1'($urandom), B_SRCA | B_SB10);
        push(11, 1'($urandom), B_RW | B_DONE);
      end
    endcase
  endfunction

  task automatic step();
    exp_t e;
    e = q.pop_front();
    opcode    = cur_op;
    zero      = cur_zero;
    mem_ready = e.rdy;
    @(negedge clk);
    check("state", 32'(state), 32'(e.st));
    check("ctl", 32'(dut_vec), 32'(e.vec));
    check("count", instr_count, model_cnt);
    if (e.vec[2]) model_cnt = model_cnt + 32'(1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
    cur_op   = op;
    cur_zero = z;
    build(op, z, wf, wm);
    while (q.size() > 0) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op;
    int         r;
    reset     = 1'b0;
    opcode    = 6'h0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    model_cnt = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_strobes", 32'(dut_strobes), 32'd0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(6'b100011, 1'b0, 0, 0);
    run_instr(6'b000100, 1'b0, 0, 0);
    run_instr(6'b000100, 1'b1, 0, 0);
    run_instr(6'b000010, 1'b0, 0, 0);
    run_instr(6'b101011, 1'b0, 0, 0);
    run_instr(6'b000000, 1'b0, 0, 0);
    run_instr(6'b001000, 1'b0, 0, 0);
    run_instr(6'b100011, 1'b0, int'(MAXW) + 1, 0);
    run_instr(6'b000000, 1'b0, int'(MAXW), 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(6'b100011, 1'b0, 1, int'(MAXW) + 1);
    run_instr(6'b101011, 1'b0, 0, int'(MAXW));
    run_instr(6'b101011, 1'b0, 2, int'(MAXW) + 1);

    // Reset in the middle of a store
    cur_op   = 6'b101011;
    cur_zero = 1'b0;
    build(cur_op, cur_zero, 0, int'(MAXW) + 1);
    while (q.size() > 0 && q[0].st != 5) step();
    opcode    = cur_op;
    mem_ready = 1'b0;
    @(negedge clk);
    check("memwr_pre", 32'(mem_write), 32'd1);
    check("count_pre", instr_count, model_cnt);
    #1 reset = 1'b0;
    #1;
    check("memwr_rst", 32'(mem_write), 32'd0);
    check("state_rst", 32'(state), 32'd0);
    check("count_rst", instr_count, 32'd0);
    check("strobes_rst", 32'(dut_strobes), 32'd0);
    q.delete();
    model_cnt = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(6'b100011, 1'b0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, 1'($urandom), $urandom_range(0, MAXW + 1), $urandom_range(0, MAXW + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
